// File: rtl/cmd_comm_pkg.sv
`default_nettype none
// ============================================================================
// Module : cmd_comm_pkg
// Brief  : Shared types and constants for the host command link.
// Rev    : 1.0  initial release
// ============================================================================
package cmd_comm_pkg;

  // Receive path: number of command bytes held so far, READY = full command
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT1  = 2'd1,
    GOT2  = 2'd2,
    READY = 2'd3
  } rx_state_e;

  // Response path: one byte in flight at a time
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_SEND = 2'd1,
    R_WAIT = 2'd2,
    R_DONE = 2'd3
  } resp_state_e;

  // 20 ms at 50 MHz
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 1_000_000;

  // Width of the inter-byte idle counter
  localparam int IDLE_CNT_W = 24;

  // Byte lanes of the 24-bit command, first received byte is the MSB lane
  localparam int BYTE_HI  = 2;
  localparam int BYTE_MID = 1;
  localparam int BYTE_LO  = 0;

endpackage : cmd_comm_pkg
`default_nettype wire

// File: rtl/resp_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : resp_tx_ctrl
// Brief  : Hands one response byte to the UART transmitter and reports
//          completion. Requests arriving while busy are dropped.
// Rev    : 1.0  initial release
// ============================================================================
module resp_tx_ctrl
  import cmd_comm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] resp_data,
  input  logic       send_resp,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       trmt,
  output logic       resp_sent,
  output logic       tx_busy
);

  resp_state_e state_q;
  logic [7:0]  tx_data_q;
  logic        trmt_q;
  logic        resp_sent_q;
  logic        tx_busy_q;

  // Response FSM; busy spans the trmt cycle through the resp_sent cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= R_IDLE;
      tx_data_q   <= 8'h00;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      tx_busy_q   <= 1'b0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (send_resp) begin
            tx_data_q <= resp_data;
            trmt_q    <= 1'b1;
            tx_busy_q <= 1'b1;
            state_q   <= R_SEND;
          end
        end
        R_SEND: begin
          trmt_q  <= 1'b0;
          state_q <= R_WAIT;
        end
        R_WAIT: begin
          if (tx_done) begin
            resp_sent_q <= 1'b1;
            state_q     <= R_DONE;
          end
        end
        R_DONE: begin
          resp_sent_q <= 1'b0;
          tx_busy_q   <= 1'b0;
          state_q     <= R_IDLE;
        end
        default: begin
          trmt_q      <= 1'b0;
          resp_sent_q <= 1'b0;
          tx_busy_q   <= 1'b0;
          state_q     <= R_IDLE;
        end
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign resp_sent = resp_sent_q;
  assign tx_busy   = tx_busy_q;

endmodule : resp_tx_ctrl
`default_nettype wire

// File: rtl/cmd_comm.sv
`default_nettype none
// ============================================================================
// Module : cmd_comm
// Brief  : Assembles 3-byte host commands from a UART receiver (MSB first,
//          with inter-byte timeout) and forwards response bytes to the
//          UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
module cmd_comm
  import cmd_comm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        tx_busy
);

  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LAST = IDLE_CNT_W'(TIMEOUT_CYC - 1);

  rx_state_e             state_q;
  logic [23:0]           cmd_q;
  logic                  clr_rx_rdy_q;
  logic [IDLE_CNT_W-1:0] idle_cnt_q;
  logic                  capture;

  // A byte is taken only while assembling and not in the cycle its clear pulses
  assign capture = rx_rdy && !clr_rx_rdy_q && (state_q != READY);

  // Receive FSM with idle counter; a capture beats a timeout in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= 24'h000000;
      clr_rx_rdy_q <= 1'b0;
      idle_cnt_q   <= '0;
    end else begin
      clr_rx_rdy_q <= 1'b0;
      case (state_q)
        IDLE, GOT1, GOT2: begin
          if (capture) begin
            clr_rx_rdy_q <= 1'b1;
            idle_cnt_q   <= '0;
            case (state_q)
              IDLE: begin
                cmd_q[BYTE_HI*8 +: 8] <= rx_data;
                state_q               <= GOT1;
              end
              GOT1: begin
                cmd_q[BYTE_MID*8 +: 8] <= rx_data;
                state_q                <= GOT2;
              end
              default: begin
                cmd_q[BYTE_LO*8 +: 8] <= rx_data;
                state_q               <= READY;
              end
            endcase
          end else if (state_q != IDLE) begin
            if (idle_cnt_q == TIMEOUT_LAST) begin
              idle_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        READY: begin
          idle_cnt_q <= '0;
          if (clr_cmd_rdy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          idle_cnt_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign cmd        = cmd_q;
  assign cmd_rdy    = (state_q == READY);
  assign clr_rx_rdy = clr_rx_rdy_q;

  resp_tx_ctrl u_resp_tx_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .resp_data (resp_data),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .trmt      (trmt),
    .resp_sent (resp_sent),
    .tx_busy   (tx_busy)
  );

endmodule : cmd_comm
`default_nettype wire

// File: tb/tb_cmd_comm.sv
`default_nettype none
// ============================================================================
// Module : tb_cmd_comm
// Brief  : Self-checking bench for cmd_comm (directed tables, corner
//          sequences, randomized traffic against a behavioural model).
// Rev    : 1.0  initial release
// ============================================================================
module tb_cmd_comm;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        tx_busy;

  int checks = 0;
  int failures = 0;
  logic rdy_at_clr;

  cmd_comm #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp_data   (resp_data),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [23:0] exp_cmd;
  } cmd_vec_t;

  cmd_vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one byte, expect it consumed on the next edge, then idle to gap cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    rdy_at_clr = cmd_rdy;
    chk("clr_rx_rdy pulse", {31'd0, clr_rx_rdy}, 32'd1);
    rx_rdy = 1'b0;
    step();
    chk("clr_rx_rdy single", {31'd0, clr_rx_rdy}, 32'd0);
    repeat (gap - 2) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Behavioural model state for random traffic
  int          m_have;
  int          m_quiet;
  logic [23:0] m_cmd;
  logic        m_clr;
  logic        m_busy, m_trmt, m_sent;
  logic [7:0]  m_txd;

  initial begin
    int bad;
    int ntrmt;
    vecs[0] = '{8'h81, 8'h0A, 8'h5C, 24'h810A5C};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 24'hFF00FF};
    vecs[2] = '{8'h00, 8'h00, 8'h01, 24'h000001};
    vecs[3] = '{8'h0C, 8'h00, 8'h00, 24'h0C0000};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 24'h123456};

    // Reset state
    #3;
    chk("reset outputs", {cmd, cmd_rdy, clr_rx_rdy, trmt, resp_sent, tx_busy},
        32'd0);
    chk("reset tx_data", {24'd0, tx_data}, 32'd0);
    do_reset();

    // Three bytes 10 cycles apart
    send_byte(8'h81, 10);
    send_byte(8'h0A, 10);
    chk("cmd_rdy low before 3rd", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h5C, 10);
    chk("cmd_rdy with 3rd clr", {31'd0, rdy_at_clr}, 32'd1);
    chk("cmd assembled", {8'd0, cmd}, 32'h00810A5C);
    chk("cmd_rdy held", {31'd0, cmd_rdy}, 32'd1);

    // Back-pressure while a command is pending
    rx_data = 8'h22;
    rx_rdy  = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (clr_rx_rdy !== 1'b0 || cmd !== 24'h810A5C || cmd_rdy !== 1'b1) bad++;
    end
    chk("backpressure hold", bad, 0);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    chk("cmd_rdy after clear", {31'd0, cmd_rdy}, 32'd0);
    chk("clr_rx_rdy still low", {31'd0, clr_rx_rdy}, 32'd0);
    step();
    chk("held byte consumed", {31'd0, clr_rx_rdy}, 32'd1);
    chk("held byte is MSB", {24'd0, cmd[23:16]}, 32'h22);
    rx_rdy = 1'b0;
    repeat (TO + 10) step();
    chk("partial timeout no rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("partial timeout cmd kept", {8'd0, cmd}, 32'h00220A5C);

    // Timeout discards a lone byte
    rx_data = 8'h11; rx_rdy = 1'b1;
    step();
    rx_rdy = 1'b0;
    repeat (TO) step();
    send_byte(8'h81, 2);
    send_byte(8'h0A, 2);
    send_byte(8'h5C, 2);
    chk("after timeout cmd", {8'd0, cmd}, 32'h00810A5C);
    chk("after timeout rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;

    // Just under the timeout the partial command survives
    rx_data = 8'hAA; rx_rdy = 1'b1;
    step();
    rx_rdy = 1'b0;
    repeat (TO - 2) step();
    send_byte(8'hBB, 2);
    send_byte(8'hCC, 2);
    chk("no early timeout cmd", {8'd0, cmd}, 32'h00AABBCC);
    chk("no early timeout rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;

    // Clear outside READY is ignored
    send_byte(8'h01, 2);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    send_byte(8'h02, 2);
    send_byte(8'h03, 2);
    chk("stray clr ignored", {7'd0, cmd_rdy, cmd}, {7'd0, 1'b1, 24'h010203});
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;

    // Command table
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].b0, 3);
      send_byte(vecs[i].b1, 3);
      send_byte(vecs[i].b2, 3);
      chk("table cmd", {8'd0, cmd}, {8'd0, vecs[i].exp_cmd});
      chk("table rdy", {31'd0, cmd_rdy}, 32'd1);
      clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
      chk("table rdy cleared", {31'd0, cmd_rdy}, 32'd0);
    end

    // Response path with an ignored second request
    resp_data = 8'hA5; send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    chk("trmt latency", {31'd0, trmt}, 32'd1);
    chk("tx_data latched", {24'd0, tx_data}, 32'hA5);
    chk("tx_busy on trmt", {31'd0, tx_busy}, 32'd1);
    ntrmt = 1;
    step();
    chk("trmt one cycle", {31'd0, trmt}, 32'd0);
    resp_data = 8'h5A; send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    if (trmt) ntrmt++;
    for (int i = 0; i < 19; i++) begin
      step();
      if (trmt) ntrmt++;
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("resp_sent latency", {31'd0, resp_sent}, 32'd1);
    chk("tx_busy on sent", {31'd0, tx_busy}, 32'd1);
    step();
    chk("resp_sent one cycle", {30'd0, resp_sent, tx_busy}, 32'd0);
    chk("single trmt", ntrmt, 1);
    chk("tx_data not overwritten", {24'd0, tx_data}, 32'hA5);
    tx_done = 1'b1; step(); tx_done = 1'b0;
    chk("stray tx_done ignored", {30'd0, resp_sent, tx_busy}, 32'd0);

    // Both paths serviced in the same cycle
    rx_data = 8'h33; rx_rdy = 1'b1; resp_data = 8'h3C; send_resp = 1'b1;
    step();
    rx_rdy = 1'b0; send_resp = 1'b0;
    chk("simultaneous", {23'd0, clr_rx_rdy, trmt, tx_data}, {23'd0, 1'b1, 1'b1, 8'h3C});

    // Asynchronous reset mid-command and mid-transmit
    do_reset();
    send_byte(8'h44, 2);
    send_byte(8'h55, 2);
    resp_data = 8'h77; send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {cmd, cmd_rdy, clr_rx_rdy, trmt, resp_sent, tx_busy},
        32'd0);
    chk("async reset tx_data", {24'd0, tx_data}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_byte(8'h0C, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    chk("post reset cmd", {7'd0, cmd_rdy, cmd}, {7'd0, 1'b1, 24'h0C0000});

    // Randomized traffic against the model
    do_reset();
    m_have = 0; m_quiet = 0; m_cmd = '0; m_clr = 1'b0;
    m_busy = 1'b0; m_trmt = 1'b0; m_sent = 1'b0; m_txd = '0;
    for (int blk = 0; blk < 8; blk++) begin
      int odds;
      odds = (blk % 2 == 0) ? 3 : 150;
      for (int c = 0; c < 400; c++) begin
        rx_rdy      = ($urandom_range(0, odds - 1) == 0);
        rx_data     = 8'($urandom);
        clr_cmd_rdy = ($urandom_range(0, 7) == 0);
        send_resp   = ($urandom_range(0, 3) == 0);
        resp_data   = 8'($urandom);
        tx_done     = ($urandom_range(0, 5) == 0);
        // receive rules: capture, release on ack, or count idle time
        if (m_have < 3 && rx_rdy && !m_clr) begin
          m_cmd[23 - 8*m_have -: 8] = rx_data;
          m_have++;
          m_quiet = 0;
          m_clr = 1'b1;
        end else begin
          m_clr = 1'b0;
          if (m_have == 3) begin
            if (clr_cmd_rdy) m_have = 0;
          end else if (m_have > 0) begin
            if (m_quiet == TO - 1) begin
              m_have = 0;
              m_quiet = 0;
            end else begin
              m_quiet++;
            end
          end
        end
        // response rules
        if (!m_busy && send_resp) begin
          m_busy = 1'b1; m_trmt = 1'b1; m_txd = resp_data;
        end else if (m_trmt) begin
          m_trmt = 1'b0;
        end else if (m_sent) begin
          m_sent = 1'b0; m_busy = 1'b0;
        end else if (m_busy && tx_done) begin
          m_sent = 1'b1;
        end
        step();
        chk("rand cmd", {7'd0, cmd_rdy, cmd}, {7'd0, (m_have == 3), m_cmd});
        chk("rand ctl", {20'd0, clr_rx_rdy, trmt, resp_sent, tx_busy, tx_data},
            {20'd0, m_clr, m_trmt, m_sent, m_busy, m_txd});
      end
    end
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cmd_comm
`default_nettype wire

// File: doc/cmd_comm.md
CMD_COMM -- requirements
Module: cmd_comm

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_000_000 (20 ms at 50 MHz), is the maximum idle clock count allowed between bytes of one partial command.
REQ-002 clk  input  1  system clock; the block has one clock and every flop is on it.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 rx_rdy  input  1  UART receiver holds a valid byte.
REQ-005 rx_data  input  8  received byte.
REQ-006 clr_rx_rdy  output  1  one-cycle pulse that consumes the held byte.
REQ-007 cmd  output  24  assembled host command.
REQ-008 cmd_rdy  output  1  cmd is valid; held until cleared.
REQ-009 clr_cmd_rdy  input  1  core acknowledges cmd.
REQ-010 resp_data  input  8  response byte from core.
REQ-011 send_resp  input  1  one-cycle request to transmit resp_data.
REQ-012 resp_sent  output  1  one-cycle pulse when the response byte has finished sending.
REQ-013 trmt  output  1  one-cycle start pulse to the UART transmitter.
REQ-014 tx_data  output  8  byte to the UART transmitter.
REQ-015 tx_done  input  1  UART transmitter finished its frame.
REQ-016 tx_busy  output  1  response path occupied, from the trmt cycle through the resp_sent cycle inclusive.

Function
REQ-017 Receive FSM states: IDLE, GOT1, GOT2, READY.
REQ-018 In IDLE, GOT1 and GOT2, a cycle with rx_rdy=1 and clr_rx_rdy=0 captures rx_data and pulses clr_rx_rdy on the next cycle.
- Bytes are consumed at most one per two cycles.
REQ-019 Byte order is MSB first:
- first byte -> cmd[23:16], then go to GOT1;
- second byte -> cmd[15:8], then go to GOT2;
- third byte -> cmd[7:0], then go to READY.
REQ-020 cmd_rdy rises on the cycle after the third byte is captured and equals (state==READY).
REQ-021 In READY, rx_rdy is not consumed (no clr_rx_rdy pulse, which provides back-pressure), and cmd is held stable.
REQ-022 clr_cmd_rdy in READY returns the FSM to IDLE; cmd_rdy is 0 on the next cycle.
- clr_cmd_rdy in any other state is ignored.
REQ-023 A 24-bit-wide idle counter clears on every byte capture and increments in GOT1 and GOT2.
- On reaching TIMEOUT_CYC-1, the FSM returns to IDLE and the partial command is discarded.
- cmd_rdy is not asserted and cmd is not altered.
REQ-024 The idle counter is held at 0 in IDLE and READY.
REQ-025 Response FSM states: R_IDLE, R_SEND, R_WAIT, R_DONE.
REQ-026 send_resp in R_IDLE latches resp_data into tx_data and moves to R_SEND.
REQ-027 R_SEND asserts trmt for exactly one cycle, then moves to R_WAIT.
REQ-028 In R_WAIT, tx_done moves the FSM to R_DONE; R_DONE pulses resp_sent for one cycle, then returns to R_IDLE.
REQ-029 Latency: send_resp at cycle N gives trmt at N+1; tx_done at cycle M gives resp_sent at M+1.
REQ-030 send_resp while tx_busy=1 is ignored, and tx_data is not overwritten.
REQ-031 tx_done outside R_WAIT is ignored.
REQ-032 The receive and response FSMs are independent, and simultaneous events on both paths are each serviced in the same cycle.

Reset
REQ-033 Assertion of rst_n, including mid-command or mid-transmit, forces both FSMs to IDLE/R_IDLE and clears the following to 0 asynchronously:
- cmd, cmd_rdy, clr_rx_rdy;
- tx_data, trmt, resp_sent, tx_busy;
- the idle counter.
REQ-034 After rst_n deasserts, the first byte received is treated as cmd[23:16].

Structure
REQ-035 A shared package cmd_comm_pkg holds:
- the receive-state and response-state enumerations;
- the default TIMEOUT_CYC;
- the byte-index constants.
REQ-036 The response path is a sub-module resp_tx_ctrl, instantiated once; the receive path and idle counter are in cmd_comm.

Verification
REQ-037 Bytes 0x81, 0x0A, 0x5C, each 10 cycles apart -> three clr_rx_rdy pulses, then cmd=0x810A5C and cmd_rdy=1 one cycle after the third capture.
REQ-038 With cmd_rdy=1, a fourth byte 0x22 is held on rx_rdy for 50 cycles -> no clr_rx_rdy and cmd unchanged; after clr_cmd_rdy the byte is consumed as the new cmd[23:16].
REQ-039 With TIMEOUT_CYC=100, one byte 0x11 is sent, then 100 idle cycles, then 0x81, 0x0A, 0x5C -> cmd=0x810A5C (0x11 discarded).
REQ-040 send_resp with resp_data=0xA5, then send_resp with 0x5A two cycles later, then tx_done after 20 cycles -> one trmt pulse with tx_data=0xA5, resp_sent one cycle after tx_done, and the 0x5A request ignored.
REQ-041 rst_n is pulsed low after two command bytes and during R_WAIT -> all outputs 0 immediately, and a following three-byte command 0x0C0000 assembles correctly.
